// File: rtl/pattern_merge_pkg.sv
// Shared types and helpers for the parametrised merged-pattern pipeline.
package pattern_merge_pkg;

  typedef enum logic {OP_NOR, OP_NAND} op_t;

  localparam int CNT_W = 16;

  // Stages are numbered from 1: odd stages NOR-merge, even stages NAND-merge.
  function automatic op_t stage_op(input int k);
    return (k % 2 == 1) ? OP_NOR : OP_NAND;
  endfunction

endpackage

// File: rtl/pattern_merge_stage.sv
// One elastic pattern stage: merges the incoming vector with its own feedback
// register and holds the result until the next stage takes it.
module pattern_merge_stage
  import pattern_merge_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter op_t OP    = OP_NOR
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             d_valid_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             take_i,
  output logic             adv_o,
  output logic             v_o,
  output logic [WIDTH-1:0] data_o
);

  logic             v_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] fb_q;
  logic [WIDTH-1:0] y_d;

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    if (OP == OP_NOR) return ~(a | b);
    else              return ~(a & b);
  endfunction

  assign y_d   = merge(d_i, fb_q);
  assign adv_o = d_valid_i & (~v_q | take_i);

  // Clear drops the beat and the feedback history but leaves data_q as-is.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
      fb_q   <= '0;
    end else if (clear_i) begin
      v_q    <= 1'b0;
      fb_q   <= '0;
    end else if (adv_o) begin
      v_q    <= 1'b1;
      data_q <= y_d;
      fb_q   <= y_d;
    end else if (take_i) begin
      v_q    <= 1'b0;
    end
  end

  assign v_o    = v_q;
  assign data_o = data_q;

endmodule

// File: rtl/pattern_merge_pipe.sv
// DEPTH-stage elastic merged-pattern pipeline with a combinational ready chain.
// Optional transfer counter port out_count under PATTERN_MERGE_PIPE_CNT_EN.
module pattern_merge_pipe
  import pattern_merge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PATTERN_MERGE_PIPE_CNT_EN
  ,
  output logic [CNT_W-1:0] out_count
`endif
);

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             d_valid;
    logic [WIDTH-1:0] d;
    logic             take;
    logic             adv;
    logic             v;
    logic [WIDTH-1:0] data;

    if (k == 0) begin : g_head
      assign d_valid = in_valid & ~clear;
      assign d       = in_data;
    end else begin : g_link
      assign d_valid = g_stage[k-1].v;
      assign d       = g_stage[k-1].data;
    end

    // A stage is emptied exactly when its successor advances.
    if (k == DEPTH - 1) begin : g_tail
      assign take = out_ready;
    end else begin : g_mid
      assign take = g_stage[k+1].adv;
    end

    pattern_merge_stage #(
      .WIDTH (WIDTH),
      .OP    (stage_op(k + 1))
    ) u_stage (
      .clk_i     (blif_clk_net),
      .rst_i     (blif_reset_net),
      .clear_i   (clear),
      .d_valid_i (d_valid),
      .d_i       (d),
      .take_i    (take),
      .adv_o     (adv),
      .v_o       (v),
      .data_o    (data)
    );
  end

  assign in_ready  = ~clear & (~g_stage[0].v | g_stage[0].take);
  assign out_valid = g_stage[DEPTH-1].v;
  assign out_data  = g_stage[DEPTH-1].data;

`ifdef PATTERN_MERGE_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net || clear) cnt_q <= '0;
    else if (out_valid && out_ready) cnt_q <= cnt_q + 1'b1;
  end

  assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_pattern_merge_pipe.sv
// Directed bench for pattern_merge_pipe with a per-cycle queue-based scoreboard.
module tb_pattern_merge_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef PATTERN_MERGE_PIPE_CNT_EN
  logic [15:0]      out_count;
`endif

  pattern_merge_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data)
`ifdef PATTERN_MERGE_PIPE_CNT_EN
    ,
    .out_count      (out_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sb_out = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Golden model: each accepted beat walks all stages in order, each stage
  // merging with the previous beat's result at that stage.
  logic [WIDTH-1:0] mfb [DEPTH];
  logic [WIDTH-1:0] expq [$];
  logic [15:0]      exp_cnt;

  function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] val;
    val = x;
    for (int k = 0; k < DEPTH; k++) begin
      if (k % 2 == 0) val = ~(val | mfb[k]);
      else            val = ~(val & mfb[k]);
      mfb[k] = val;
    end
    return val;
  endfunction

  initial begin
    logic             prev_hold;
    logic [WIDTH-1:0] prev_data;
    prev_hold = 1'b0;
    prev_data = '0;
    exp_cnt   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete();
        for (int k = 0; k < DEPTH; k++) mfb[k] = '0;
        exp_cnt   = '0;
        prev_hold = 1'b0;
      end else begin
        if (clear) chk("sb_clear_ready", in_ready, 1'b0);
        else chk("sb_ready_rule", in_ready,
                 !(expq.size() == DEPTH && !out_ready));
        if (prev_hold) begin
          chk("sb_hold_valid", out_valid, 1'b1);
          chk("sb_hold_data", out_data, prev_data);
        end
`ifdef PATTERN_MERGE_PIPE_CNT_EN
        chk("sb_count", out_count, exp_cnt);
`endif
        if (expq.size() == 0) begin
          chk("sb_empty_no_valid", out_valid, 1'b0);
        end else if (out_valid && out_ready) begin
          chk("sb_data", out_data, expq.pop_front());
          sb_out++;
          exp_cnt = exp_cnt + 16'd1;
        end
        prev_hold = out_valid && !out_ready && !clear;
        prev_data = out_data;
        if (clear) begin
          expq.delete();
          for (int k = 0; k < DEPTH; k++) mfb[k] = '0;
          exp_cnt = '0;
        end else if (in_valid && in_ready) begin
          expq.push_back(golden(in_data));
        end
      end
    end
  end

  task automatic stream(input int n);
    int acc_n;
    int c;
    acc_n = 0;
    c = 0;
    out_ready = 1'b1;
    while (acc_n < n && c < n + 50) begin
      in_valid = 1'b1;
      in_data  = WIDTH'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) acc_n++;
      @(posedge clk); #1;
      c++;
    end
    in_valid = 1'b0;
    repeat (DEPTH + 1) @(posedge clk);
    #1;
    chk("stream_accepted", acc_n, n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  logic [WIDTH-1:0] lit3 [4] = '{8'h0F, 8'h3C, 8'h00, 8'h00};
  logic [WIDTH-1:0] exp3 [4] = '{8'h00, 8'h03, 8'hFC, 8'h03};

  initial begin
    int idx, oidx, nout, acc_n, cyc, start;
    logic acc, tog;
    logic [WIDTH-1:0] got;

    rst = 1'b1; clear = 1'b0; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;

    // Reset held two cycles with a valid beat offered
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_fb1", dut.g_stage[0].u_stage.fb_q, 8'h00);
    chk("rst_fb2", dut.g_stage[1].u_stage.fb_q, 8'h00);
    chk("rst_fb3", dut.g_stage[2].u_stage.fb_q, 8'h00);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_beat", out_valid, 1'b0);
    end

    // Unstalled pair 0x0F, 0x3C
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h0F;
    @(negedge clk); chk("t2_ready", in_ready, 1'b1);
    @(posedge clk); #1 in_data = 8'h3C;
    @(negedge clk);
    chk("t2_fb1_a", dut.g_stage[0].u_stage.fb_q, 8'hF0);
    chk("t2_ov_a", out_valid, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("t2_fb1_b", dut.g_stage[0].u_stage.fb_q, 8'h03);
    chk("t2_fb2_a", dut.g_stage[1].u_stage.fb_q, 8'hFF);
    chk("t2_ov_b", out_valid, 1'b0);
    @(negedge clk);
    chk("t2_out1_valid", out_valid, 1'b1);
    chk("t2_out1_data", out_data, 8'h00);
    chk("t2_fb2_b", dut.g_stage[1].u_stage.fb_q, 8'hFC);
    chk("t2_fb3_a", dut.g_stage[2].u_stage.fb_q, 8'h00);
    @(negedge clk);
    chk("t2_out2_valid", out_valid, 1'b1);
    chk("t2_out2_data", out_data, 8'h03);
    @(negedge clk);
    chk("t2_drained", out_valid, 1'b0);

    // Stalled stream: 3 beats fill the pipe, then release
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0; out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 4);
      in_data  = (idx < 4) ? lit3[idx] : 8'h00;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
      #1;
    end
    chk("t3_buffered", idx, 3);
    @(negedge clk);
    chk("t3_full_ready", in_ready, 1'b0);
    chk("t3_stall_valid", out_valid, 1'b1);
    chk("t3_stall_data", out_data, 8'h00);
    @(posedge clk); #1 out_ready = 1'b1;
    oidx = 0;
    for (int c = 0; c < 15; c++) begin
      in_valid = (idx < 4);
      in_data  = (idx < 4) ? lit3[idx] : 8'h00;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (oidx < 4) chk("t3_seq", out_data, exp3[oidx]);
        oidx++;
      end
      @(posedge clk);
      if (acc) idx++;
      #1;
    end
    in_valid = 1'b0;
    chk("t3_out_count", oidx, 4);

    // Mid-stream clear
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0; in_valid = 1'b1; in_data = 8'h0F;
    @(negedge clk); chk("t4_accept", in_ready, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0; clear = 1'b1;
    @(negedge clk); chk("t4_clear_ready", in_ready, 1'b0);
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("t4_ov", out_valid, 1'b0);
    chk("t4_fb1", dut.g_stage[0].u_stage.fb_q, 8'h00);
    chk("t4_fb2", dut.g_stage[1].u_stage.fb_q, 8'h00);
    chk("t4_fb3", dut.g_stage[2].u_stage.fb_q, 8'h00);
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h0F;
    @(posedge clk); #1 in_valid = 1'b0;
    nout = 0;
    got = 8'hAA;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        nout++;
        got = out_data;
      end
    end
    chk("t4_nout", nout, 1);
    chk("t4_data", got, 8'h00);

    // Toggling in_valid with random backpressure
    void'($urandom(32'd20240611));
    start = sb_out;
    acc_n = 0;
    cyc = 0;
    tog = 1'b1;
    @(posedge clk); #1;
    while (acc_n < 200 && cyc < 5000) begin
      in_valid  = tog;
      tog       = ~tog;
      in_data   = WIDTH'($urandom_range(0, 255));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) acc_n++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("t5_accepted", acc_n, 200);
    cyc = 0;
    while (sb_out - start < 200 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t5_delivered", sb_out - start, 200);

`ifdef PATTERN_MERGE_PIPE_CNT_EN
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    stream(5);
    chk("cnt_five", out_count, 16'd5);
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    chk("cnt_clear", out_count, 16'd0);
    stream(65535);
    chk("cnt_ffff", out_count, 16'hFFFF);
    stream(1);
    chk("cnt_wrap", out_count, 16'h0000);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
